// File: rtl/pipeline_ctrl.sv
// ============================================================================
// pipeline_ctrl
// ----------------------------------------------------------------------------
// Central hazard and sequencing controller for the five-stage pipeline.
// Each cycle it produces the PC enable and the enable/flush controls of the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also latches the halted
// state and keeps two saturating performance counters.
//
// Ports
//   CLK           in   system clock, rising edge
//   nRST          in   asynchronous active-low reset
//   ihit          in   instruction fetch completes this cycle
//   dhit          in   data access completes this cycle
//   dren_mem      in   MEM-stage instruction requests a data read
//   dwen_mem      in   MEM-stage instruction requests a data write
//   id_rs, id_rt  in   source registers of the instruction in ID
//   ex_memread    in   instruction in EX is a load
//   ex_rd         in   destination register of the instruction in EX
//   redirect_mem  in   branch/jump in MEM resolved taken
//   halt_wb       in   halt instruction is in WB
//   pc_en         out  PC loads next value
//   *_en          out  pipeline register loads its input
//   *_flush       out  pipeline register clears at next edge (wins over enable)
//   halted        out  processor halted (registered)
//   stall_cnt     out  RUN cycles with pc_en=0, saturating at 0xFFFF
//   redirect_cnt  out  redirects taken, saturating at 0xFFFF
// ============================================================================
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dren_mem,
    input  logic        dwen_mem,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        redirect_mem,
    input  logic        halt_wb,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic mem_wait;
    logic load_use;
    logic count_stall;
    logic count_redirect;

    assign mem_wait = (dren_mem | dwen_mem) & ~dhit;
    assign load_use = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

    // State register: reset always returns to RUN.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a halt reaching WB is terminal until reset.
    always_comb begin
        next_state = state;
        if (state == RUN && halt_wb) begin
            next_state = HALTED;
        end
    end

    // Output decode: fixed-priority hazard resolution. Holding reset low
    // forces every control to 0 regardless of the registered state.
    always_comb begin
        pc_en          = 1'b0;
        if_id_en       = 1'b0;
        id_ex_en       = 1'b0;
        ex_mem_en      = 1'b0;
        mem_wb_en      = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        count_stall    = 1'b0;
        count_redirect = 1'b0;
        if (nRST && state == RUN) begin
            if (halt_wb) begin
                count_stall = 1'b1;
            end else if (mem_wait) begin
                count_stall = 1'b1;
            end else if (redirect_mem) begin
                // The pending fetch is wrong-path, so ihit does not matter.
                pc_en          = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                ex_mem_flush   = 1'b1;
                mem_wb_en      = 1'b1;
                count_redirect = 1'b1;
            end else if (load_use || !ihit) begin
                // Hold IF/ID and the PC, push a bubble into EX, drain the rest.
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                count_stall = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    assign halted = (state == HALTED);

    // Performance counters: saturate at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt    <= 16'd0;
            redirect_cnt <= 16'd0;
        end else begin
            if (count_stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (count_redirect && redirect_cnt != 16'hFFFF) begin
                redirect_cnt <= redirect_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipeline. Each cycle it generates the enable and synchronous-flush controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). The decisions come from memory-wait status, load-use hazards, taken branches/jumps resolved in MEM, and halt reaching WB. It latches the halted state and keeps two saturating performance counters.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- dren_mem, dwen_mem  in  1 each  data read/write requested by the instruction in MEM.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- redirect_mem  in  1  branch/jump in MEM resolved taken; PC mux already selects the target.
- halt_wb  in  1  halt instruction is in WB.
- pc_en  out  1  PC loads next value.
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register loads its input.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  register clears to 0 at the next edge. Flush overrides enable.
- halted  out  1  processor halted (registered).
- stall_cnt  out  16  cycles with pc_en=0 while running, saturating.
- redirect_cnt  out  16  redirect events taken, saturating.

## Operation
- States: RUN and HALTED. Reset enters RUN.
- Derived terms:
  - mem_wait = (dren_mem | dwen_mem) & ~dhit.
  - load_use = ex_memread & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).
- In RUN, the first matching case below decides the outputs. Any output not listed is 0.
  1. halt_wb: all enables and flushes 0. Next state is HALTED.
  2. mem_wait: all enables 0 (full freeze), no flushes.
  3. redirect_mem: pc_en=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, mem_wb_en=1. ihit is ignored; the outstanding fetch is discarded. redirect_cnt increments.
  4. load_use: pc_en=0, if_id_en=0, id_ex_flush=1 (bubble), ex_mem_en=1, mem_wb_en=1.
  5. ~ihit: same outputs as case 4. The instruction in IF/ID is held and a bubble is inserted into EX.
  6. Otherwise: all four enables and pc_en are 1, no flushes.
- In HALTED: all enables and flushes 0 and halted=1. Only nRST exits this state.
- Counters:
  - stall_cnt increments on every RUN cycle with pc_en=0, including case 1.
  - Both counters saturate at 0xFFFF. They never wrap.
  - Neither counter changes in HALTED.

## Timing
- All enable and flush outputs are combinational from the inputs and the registered state. There is zero-cycle latency within the cycle in which they act.
- halted, state and both counters update on the rising CLK edge. halted rises on the edge after the cycle in which halt_wb is seen.
- While nRST=0:
  - all enables and flushes are forced to 0;
  - halted=0, stall_cnt=0, redirect_cnt=0;
  - state=RUN.
  - Deassertion takes effect at the next edge with normal priority.
- Simultaneous events resolve strictly by the priority list:
  - redirect + load_use means redirect only.
  - redirect + mem_wait means freeze. The branch stays in MEM and redirects once dhit arrives.
  - load_use + ~ihit gives identical outputs; stall_cnt increments once.
- Reset asserted mid-stall or in HALTED clears everything asynchronously, with no residual state.

## Test plan
- Reset then idle:
  - Stimulus: nRST=0 for 2 cycles, then ihit=1 with all other inputs 0.
  - Required: all outputs 0 during reset; pc_en and all four enables =1 from the first cycle after release; counters stay 0.
- Load-use:
  - Stimulus: ex_memread=1, ex_rd=8, id_rt=8, ihit=1 for one cycle.
  - Required: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1, and stall_cnt=1 after the edge.
  - Repeat with ex_rd=0: no stall.
- Memory wait:
  - Stimulus: dren_mem=1, dhit=0 for 3 cycles, then dhit=1.
  - Required: all enables 0 for 3 cycles, then normal advance; stall_cnt=3.
- Redirect priority:
  - Stimulus: redirect_mem=1 together with load_use=1 and ihit=0.
  - Required: pc_en=1; if_id, id_ex and ex_mem flushes =1; mem_wb_en=1; redirect_cnt=1.
  - Repeat with mem_wait=1: full freeze and no count, until dhit.
- Halt:
  - Stimulus: halt_wb=1 for one cycle, then drop it.
  - Required: enables 0 in that cycle; halted=1 from the next edge and held; all enables stay 0; counters frozen.
  - Then nRST pulse: halted=0.
- Saturation:
  - Stimulus: force ~ihit for 65540 cycles.
  - Required: stall_cnt stops at 0xFFFF and never wraps to 0.
